// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Owns the single data-memory/bridge port and shares it between
//             the CPU MEM stage (cpu_*) and a DMA master (dma_*). Each access
//             runs as a registered bus transaction with a variable-latency
//             ack. The block generates byte enables and lane-replicated store
//             data. It sign/zero-extends load data by size and address
//             offset, and drives the CPU pipeline stall.
//  Ports    : clk, reset_n (async, active-low)
//             cpu_req/we/size/sgn/addr/wdata -> cpu_done/err/rdata, cpu_stall
//             dma_req/we/size/sgn/addr/wdata -> dma_done/err/rdata
//             bus_req/we/addr/byteen/wdata   <- bus_ack/rdata
//  Params   : TIMEOUT - BUSY cycles without bus_ack before abort (1..2^CNT_W-1)
//             CNT_W   - width of the timeout counter
//  Options  : MEM_ALIGN_CHK_EN - when defined, misaligned word/half accesses
//             complete at once with err and never reach the bus
//  Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 8
) (
   input  logic        clk,
   input  logic        reset_n,
   // CPU MEM-stage port
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [1:0]  cpu_size,
   input  logic        cpu_sgn,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic        cpu_done,
   output logic        cpu_err,
   output logic [31:0] cpu_rdata,
   output logic        cpu_stall,
   // DMA master port
   input  logic        dma_req,
   input  logic        dma_we,
   input  logic [1:0]  dma_size,
   input  logic        dma_sgn,
   input  logic [31:0] dma_addr,
   input  logic [31:0] dma_wdata,
   output logic        dma_done,
   output logic        dma_err,
   output logic [31:0] dma_rdata,
   // Memory / bridge bus
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_byteen,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata
);

   localparam logic [1:0] c_IDLE = 2'd0;
   localparam logic [1:0] c_BUSY = 2'd1;
   localparam logic [1:0] c_RESP = 2'd2;

   localparam logic c_ID_CPU = 1'b0;
   localparam logic c_ID_DMA = 1'b1;

   localparam logic [1:0] c_SZ_HALF = 2'b01;
   localparam logic [1:0] c_SZ_BYTE = 2'b10;

   localparam logic [CNT_W-1:0] c_TIMEOUT = CNT_W'(TIMEOUT);

   // ------------------------------------------------------------------------
   // Lane helpers. Size 2'b11 is reserved and falls through to word.
   // ------------------------------------------------------------------------
   function automatic logic [3:0] f_byteen(input logic [1:0] size,
                                           input logic [1:0] off);
      logic [3:0] be;
      case (size)
         c_SZ_HALF: be = off[1] ? 4'b1100 : 4'b0011;
         c_SZ_BYTE: be = 4'b0001 << off;
         default:   be = 4'b1111;
      endcase
      return be;
   endfunction

   function automatic logic [31:0] f_wrep(input logic [1:0]  size,
                                          input logic [31:0] wd);
      logic [31:0] d;
      case (size)
         c_SZ_HALF: d = {2{wd[15:0]}};
         c_SZ_BYTE: d = {4{wd[7:0]}};
         default:   d = wd;
      endcase
      return d;
   endfunction

   function automatic logic [31:0] f_ld_ext(input logic [1:0]  size,
                                            input logic        sgn,
                                            input logic [1:0]  off,
                                            input logic [31:0] raw);
      logic [15:0] h;
      logic [7:0]  b;
      logic [31:0] d;
      h = off[1] ? raw[31:16] : raw[15:0];
      case (off)
         2'd0:    b = raw[7:0];
         2'd1:    b = raw[15:8];
         2'd2:    b = raw[23:16];
         default: b = raw[31:24];
      endcase
      case (size)
         c_SZ_HALF: d = {{16{sgn & h[15]}}, h};
         c_SZ_BYTE: d = {{24{sgn & b[7]}}, b};
         default:   d = raw;
      endcase
      return d;
   endfunction

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   logic [1:0]       r_state;
   logic [1:0]       w_state_nxt;
   logic             r_id;
   logic             r_last_grant;
   logic             r_bus_req;
   logic             r_we;
   logic [31:0]      r_bus_addr;
   logic [3:0]       r_byteen;
   logic [31:0]      r_wdata;
   logic [1:0]       r_size;
   logic             r_sgn;
   logic [1:0]       r_off;
   logic [CNT_W-1:0] r_cnt;
   logic             r_err;
   logic [31:0]      r_rdata;

   // ------------------------------------------------------------------------
   // Arbitration: a sole requester wins; on a tie the port that did not win
   // last time gets the bus.
   // ------------------------------------------------------------------------
   logic        w_any_req;
   logic        w_pick_dma;
   logic        w_sel_we;
   logic [1:0]  w_sel_size;
   logic        w_sel_sgn;
   logic [31:0] w_sel_addr;
   logic [31:0] w_sel_wdata;
   logic        w_misalign;
   logic [CNT_W-1:0] w_cnt_inc;
   logic        w_timeout;
   logic [31:0] w_ld_ext;

   assign w_any_req  = cpu_req | dma_req;
   assign w_pick_dma = dma_req & (~cpu_req | (r_last_grant == c_ID_CPU));

   assign w_sel_we    = w_pick_dma ? dma_we    : cpu_we;
   assign w_sel_size  = w_pick_dma ? dma_size  : cpu_size;
   assign w_sel_sgn   = w_pick_dma ? dma_sgn   : cpu_sgn;
   assign w_sel_addr  = w_pick_dma ? dma_addr  : cpu_addr;
   assign w_sel_wdata = w_pick_dma ? dma_wdata : cpu_wdata;

`ifdef MEM_ALIGN_CHK_EN
   always_comb begin
      case (w_sel_size)
         c_SZ_HALF: w_misalign = w_sel_addr[0];
         c_SZ_BYTE: w_misalign = 1'b0;
         default:   w_misalign = |w_sel_addr[1:0];
      endcase
   end
`else
   assign w_misalign = 1'b0;
`endif

   // Counter counts completed ack-less BUSY cycles; abort on the cycle that
   // would make it reach TIMEOUT, so bus_req is high for exactly TIMEOUT cycles.
   assign w_cnt_inc = r_cnt + CNT_W'(1);
   assign w_timeout = ~bus_ack & (w_cnt_inc == c_TIMEOUT);
   assign w_ld_ext  = f_ld_ext(r_size, r_sgn, r_off, bus_rdata);

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= c_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: next state
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_IDLE: begin
            if (w_any_req) begin
               w_state_nxt = w_misalign ? c_RESP : c_BUSY;
            end
         end
         c_BUSY: begin
            if (bus_ack || w_timeout) begin
               w_state_nxt = c_RESP;
            end
         end
         c_RESP:  w_state_nxt = c_IDLE;
         default: w_state_nxt = c_IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // FSM: outputs. The done pulse goes only to the port that owns the grant.
   // ------------------------------------------------------------------------
   always_comb begin
      cpu_done  = 1'b0;
      dma_done  = 1'b0;
      if (r_state == c_RESP) begin
         cpu_done = (r_id == c_ID_CPU);
         dma_done = (r_id == c_ID_DMA);
      end
      cpu_err   = cpu_done & r_err;
      dma_err   = dma_done & r_err;
      cpu_rdata = cpu_done ? r_rdata : 32'd0;
      dma_rdata = dma_done ? r_rdata : 32'd0;
      cpu_stall = cpu_req & ~cpu_done;
   end

   // ------------------------------------------------------------------------
   // Transaction datapath
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_id         <= c_ID_CPU;
         r_last_grant <= c_ID_DMA;
         r_bus_req    <= 1'b0;
         r_we         <= 1'b0;
         r_bus_addr   <= 32'd0;
         r_byteen     <= 4'd0;
         r_wdata      <= 32'd0;
         r_size       <= 2'd0;
         r_sgn        <= 1'b0;
         r_off        <= 2'd0;
         r_cnt        <= '0;
         r_err        <= 1'b0;
         r_rdata      <= 32'd0;
      end else begin
         case (r_state)
            c_IDLE: begin
               if (w_any_req) begin
                  r_id         <= w_pick_dma;
                  r_last_grant <= w_pick_dma;
                  r_we         <= w_sel_we;
                  r_bus_addr   <= {w_sel_addr[31:2], 2'b00};
                  r_byteen     <= f_byteen(w_sel_size, w_sel_addr[1:0]);
                  r_wdata      <= f_wrep(w_sel_size, w_sel_wdata);
                  r_size       <= w_sel_size;
                  r_sgn        <= w_sel_sgn;
                  r_off        <= w_sel_addr[1:0];
                  r_cnt        <= '0;
                  // A rejected (misaligned) access never touches the bus.
                  r_bus_req    <= ~w_misalign;
                  r_err        <= w_misalign;
                  r_rdata      <= 32'd0;
               end
            end
            c_BUSY: begin
               if (bus_ack) begin
                  r_bus_req <= 1'b0;
                  r_err     <= 1'b0;
                  r_rdata   <= w_ld_ext;
               end else begin
                  r_cnt <= w_cnt_inc;
                  if (w_timeout) begin
                     r_bus_req <= 1'b0;
                     r_err     <= 1'b1;
                     r_rdata   <= 32'd0;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus_req    = r_bus_req;
   assign bus_we     = r_we;
   assign bus_addr   = r_bus_addr;
   assign bus_byteen = r_byteen;
   assign bus_wdata  = r_wdata;

endmodule
`default_nettype wire
